// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between an sram-like core fetch port
// and an sram-like memory bus; misses refill a whole line one word at a time.
module icache #(
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [1:0]  cpu_size,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_uncached,
   output logic [31:0] cpu_rdata,
   output logic        cpu_addr_ok,
   output logic        cpu_data_ok,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_uncached,
   input  logic [31:0] mem_rdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok
);

   localparam int WB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(SETS);
   localparam int TB = 30 - WB - IB;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS_REQ,
      MISS_WAIT,
      UNC_REQ,
      UNC_WAIT
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [31:2]     req_addr;
   logic [WB-1:0]   cnt;
   logic [SETS-1:0] valid;

   logic [TB-1:0]   tag_mem  [SETS];
   logic [31:0]     data_mem [SETS*LINE_WORDS];

   logic [IB-1:0]    idx;
   logic [WB-1:0]    word;
   logic [TB-1:0]    tag;
   logic [IB+WB-1:0] rd_sel;
   logic [IB+WB-1:0] wr_sel;
   logic             hit;
   logic             last;
   logic             refill_we;
   logic             unused_bits;

   // Write-side attributes, byte lanes and the low address bits carry no meaning for fetches.
   assign unused_bits = ^{cpu_wr, cpu_size, cpu_wdata, cpu_addr[1:0]};

   assign idx       = req_addr[2+WB +: IB];
   assign word      = req_addr[2 +: WB];
   assign tag       = req_addr[31 -: TB];
   assign rd_sel    = {idx, word};
   assign wr_sel    = {idx, cnt};
   assign hit       = valid[idx] && (tag_mem[idx] == tag);
   assign last      = (cnt == WB'(LINE_WORDS - 1));
   assign refill_we = (state == MISS_WAIT) && mem_data_ok;

   assign mem_wr    = 1'b0;
   assign mem_size  = 2'b10;
   assign mem_wdata = 32'h0;

   // NOTE: every output and the next state get a default first so no path can infer a latch.
   always_comb begin
      state_nx     = state;
      cpu_addr_ok  = 1'b0;
      cpu_data_ok  = 1'b0;
      cpu_rdata    = 32'h0;
      mem_req      = 1'b0;
      mem_addr     = 32'h0;
      mem_uncached = 1'b0;

      case (state)
         IDLE: begin
            cpu_addr_ok = cpu_req;
            if (cpu_req) begin
               state_nx = cpu_uncached ? UNC_REQ : LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               cpu_data_ok = 1'b1;
               cpu_rdata   = data_mem[rd_sel];
               state_nx    = IDLE;
            end else begin
               state_nx = MISS_REQ;
            end
         end
         MISS_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {tag, idx, cnt, 2'b00};
            if (mem_addr_ok) begin
               state_nx = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (mem_data_ok) begin
               state_nx = last ? LOOKUP : MISS_REQ;
            end
         end
         UNC_REQ: begin
            mem_req      = 1'b1;
            mem_uncached = 1'b1;
            mem_addr     = {req_addr, 2'b00};
            if (mem_addr_ok) begin
               state_nx = UNC_WAIT;
            end
         end
         UNC_WAIT: begin
            if (mem_data_ok) begin
               cpu_data_ok = 1'b1;
               cpu_rdata   = mem_rdata;
               state_nx    = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      // The core and the bus must see a quiet port for the whole reset cycle.
      if (rst) begin
         cpu_addr_ok  = 1'b0;
         cpu_data_ok  = 1'b0;
         cpu_rdata    = 32'h0;
         mem_req      = 1'b0;
         mem_addr     = 32'h0;
         mem_uncached = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req_addr <= '0;
         cnt      <= '0;
         valid    <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cpu_req) begin
            req_addr <= cpu_addr[31:2];
         end
         if (state == LOOKUP && !hit) begin
            cnt <= '0;
         end
         if (refill_we) begin
            cnt        <= cnt + WB'(1);
            valid[idx] <= last;
         end
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits alone decide whether they are used.
   always_ff @(posedge clk) begin
      if (refill_we && !rst) begin
         data_mem[wr_sel] <= mem_rdata;
         if (last) begin
            tag_mem[idx] <= tag;
         end
      end
   end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches push expected words and bus
// requests into queues; a negedge monitor pops and compares them.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_wr;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_uncached;
   logic [31:0] cpu_rdata;
   logic        cpu_addr_ok;
   logic        cpu_data_ok;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_uncached;
   logic [31:0] mem_rdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;

   always #5 clk = ~clk;

   icache #(.LINE_WORDS(4), .SETS(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req      (cpu_req),
      .cpu_wr       (cpu_wr),
      .cpu_size     (cpu_size),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_uncached (cpu_uncached),
      .cpu_rdata    (cpu_rdata),
      .cpu_addr_ok  (cpu_addr_ok),
      .cpu_data_ok  (cpu_data_ok),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_uncached (mem_uncached),
      .mem_rdata    (mem_rdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok)
   );

   typedef struct {
      logic [31:0] addr;
      logic        unc;
   } mreq_t;

   mreq_t       mexp_q[$];
   logic [31:0] dexp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          last_done;

   // Memory model: addr_ok after addr_wait stalled cycles, data_ok the cycle after.
   int          addr_wait;
   int          wait_cnt;
   logic        pend;
   logic        pend_unc;
   logic [31:0] pend_addr;
   logic [31:0] base;
   logic [31:0] unc_word;
   logic        stray;

   assign mem_addr_ok = mem_req && (wait_cnt == addr_wait);
   assign mem_data_ok = pend | stray;
   assign mem_rdata   = stray ? 32'hDEAD_BEEF :
                        pend_unc ? unc_word : base + {30'h0, pend_addr[3:2]};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         pend     <= 1'b0;
         pend_unc <= 1'b0;
         wait_cnt <= 0;
      end else begin
         pend      <= mem_req && mem_addr_ok;
         pend_addr <= mem_addr;
         pend_unc  <= mem_uncached;
         wait_cnt  <= (mem_req && !mem_addr_ok) ? wait_cnt + 1 : 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Monitor: compares every returned word and every accepted bus request.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr  = 32'h0;
   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_data_ok) begin
            if (dexp_q.size() == 0) fail_now("unexpected cpu_data_ok");
            else check("cpu_rdata", cpu_rdata, dexp_q.pop_front());
         end
         if (mem_req && mem_addr_ok) begin
            if (mexp_q.size() == 0) begin
               fail_now("unexpected mem request");
            end else begin
               mreq_t e;
               e = mexp_q.pop_front();
               check("mem_addr", mem_addr, e.addr);
               check("mem_uncached", {31'h0, mem_uncached}, {31'h0, e.unc});
               check("mem_wr_size", {29'h0, mem_wr, mem_size}, 32'h2);
            end
         end
         if (prev_stall) begin
            check("stall mem_req held", {31'h0, mem_req}, 32'h1);
            check("stall mem_addr held", mem_addr, prev_addr);
         end
         prev_stall <= mem_req && !mem_addr_ok;
         prev_addr  <= mem_addr;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic expect_line(input logic [31:0] line);
      for (int i = 0; i < 4; i++) begin
         mreq_t e;
         e.addr = line + 32'(i * 4);
         e.unc  = 1'b0;
         mexp_q.push_back(e);
      end
   endtask

   task automatic accept(input logic [31:0] a, input logic u, output int t0);
      t0 = -1;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_addr = a; cpu_uncached = u;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (cpu_addr_ok) begin
            t0 = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_uncached = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic u, input logic [31:0] d, input int lat);
      int t0;
      int t1;
      t1 = -1;
      dexp_q.push_back(d);
      accept(a, u, t0);
      if (t0 < 0) begin
         fail_now("accept timeout");
         dexp_q.delete();
         return;
      end
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (cpu_data_ok) begin
            t1 = cyc;
            break;
         end
      end
      if (t1 < 0) begin
         fail_now("cpu_data_ok timeout");
         dexp_q.delete();
      end else begin
         check("latency", 32'(t1 - t0), 32'(lat));
      end
      last_done = t1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      int t0;
      int seen;
      rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h104; cpu_uncached = 1'b0;
      cpu_wr = 1'b0; cpu_size = 2'b10; cpu_wdata = 32'h0;
      addr_wait = 0; base = 32'h0; unc_word = 32'h0; stray = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst cpu_addr_ok", {31'h0, cpu_addr_ok}, 32'h0);
      check("rst cpu_data_ok", {31'h0, cpu_data_ok}, 32'h0);
      check("rst cpu_rdata", cpu_rdata, 32'h0);
      check("rst mem_req", {31'h0, mem_req}, 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst mem_unc_wr_size", {29'h0, mem_uncached, mem_wr, mem_size}, 32'h2);
      check("rst mem_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; cpu_req = 1'b0;

      // Cold miss, then hit in the filled line.
      base = 32'hA0;
      expect_line(32'h100);
      fetch(32'h104, 1'b0, 32'hA1, 10);
      fetch(32'h10C, 1'b0, 32'hA3, 1);

      // Back-to-back hits every two cycles.
      for (int i = 0; i < 4; i++) begin
         prev = last_done;
         fetch((i % 2 == 0) ? 32'h104 : 32'h108, 1'b0, (i % 2 == 0) ? 32'hA1 : 32'hA2, 1);
         check("hit interval", 32'(last_done - prev), 32'd2);
      end

      // Conflict eviction and re-miss of the evicted line.
      base = 32'hB0;
      expect_line(32'h500);
      fetch(32'h500, 1'b0, 32'hB0, 10);
      base = 32'hC0;
      expect_line(32'h100);
      fetch(32'h100, 1'b0, 32'hC0, 10);

      // Uncached pass-through, then the same address cached still misses.
      unc_word = 32'h3C08_BFC0;
      mexp_q.push_back('{addr: 32'hBFC0_0000, unc: 1'b1});
      fetch(32'hBFC0_0000, 1'b1, 32'h3C08_BFC0, 2);
      base = 32'hD0;
      expect_line(32'hBFC0_0000);
      fetch(32'hBFC0_0000, 1'b0, 32'hD0, 10);

      // Backpressure: three stalled cycles per request.
      addr_wait = 3;
      base = 32'hE0;
      expect_line(32'h200);
      fetch(32'h208, 1'b0, 32'hE2, 22);
      addr_wait = 0;
      fetch(32'h20C, 1'b0, 32'hE3, 1);

      // Reset after the second refill word, then a stray data_ok.
      base = 32'hF0;
      expect_line(32'h300);
      accept(32'h304, 1'b0, t0);
      if (t0 < 0) fail_now("accept timeout");
      seen = 0;
      for (int n = 0; n < 100 && seen < 2; n++) begin
         @(negedge clk);
         if (mem_data_ok) seen++;
      end
      check("data_ok count before reset", 32'(seen), 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      mexp_q.delete();
      @(negedge clk);
      check("mem_req in reset", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      stray = 1'b1;
      @(negedge clk);
      check("stray cpu_data_ok", {31'h0, cpu_data_ok}, 32'h0);
      check("stray mem_req", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      stray = 1'b0;
      base = 32'hF8;
      expect_line(32'h300);
      fetch(32'h304, 1'b0, 32'hF9, 10);
      base = 32'hC0;
      expect_line(32'h100);
      fetch(32'h10C, 1'b0, 32'hC3, 10);

      repeat (3) @(posedge clk);
      check("mem queue drained", 32'(mexp_q.size()), 32'd0);
      check("data queue drained", 32'(dexp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
